uart_buf_tx: RTL and testbench
==============================

Name: uart_buf_tx

Overview:
- Word-to-byte serializer in front of the UART transmitter. It is the transmit-side counterpart of the UART receive word buffer.
- On a start request it latches a 32-bit word. It then feeds the word to the UART transmitter one byte at a time, LSB byte first.
- Each byte uses a start/ready handshake. The block reports busy, done and error to the game logic.
- Byte order matches the receive buffer: byte 0 ([7:0]) goes first, byte 3 ([31:24]) goes last.

Parameters:
- NBYTES, 4, number of bytes per word. Legal range 1..4; the bytes used are txbuf[8*NBYTES-1:0].
- GAP_CYCLES, 0, idle clk cycles inserted between consecutive bytes. Range 0..255.
- ACK_TIMEOUT, 16, max clk cycles to wait for tx_ready to fall after tx_start. Range 1..255.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  request to send txbuf. Sampled only in IDLE.
- txbuf  input  32  word to send. Latched on an accepted start.
- tx_ready  input  1  UART transmitter idle flag. High means it can accept a byte.
- tx_start  output  1  one-cycle pulse; tells the UART transmitter to send txbus.
- txbus  output  8  byte presented to the UART transmitter. Stable from tx_start until the byte completes.
- busy  output  1  high from the cycle after an accepted start until done or err.
- done  output  1  one-cycle pulse after the last byte completes.
- err  output  1  one-cycle pulse on handshake timeout.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE. All outputs 0: tx_start, txbus, busy, done, err. Byte index, gap counter and timeout counter all 0. Latched word 0.
- Reset mid-frame aborts the frame. No done or err is produced. tx_start drops immediately.

States:
- IDLE
  - start=1 -> latch txbuf into shadow register, idx=0, go to WAIT_RDY.
  - start=0 -> stay.
  - done and err are not set here.
- WAIT_RDY
  - busy=1. txbus = byte idx of the shadow register.
  - tx_ready=1 -> assert tx_start for exactly one cycle, clear timeout counter, go to WAIT_ACK.
- WAIT_ACK
  - tx_ready=0 -> go to WAIT_CPL.
  - Otherwise increment the timeout counter.
  - Counter reaches ACK_TIMEOUT -> pulse err, go to IDLE. The rest of the frame is dropped.
- WAIT_CPL
  - tx_ready=1 means the byte is complete.
  - If idx==last: go to IDLE and pulse done in that cycle. busy is low from the next cycle.
  - Else: idx+1, go to GAP if GAP_CYCLES>0, otherwise go to WAIT_RDY.
- GAP
  - Count GAP_CYCLES cycles, then go to WAIT_RDY.

Timing and boundary rules:
- Latency with tx_ready already high: tx_start is asserted 1 cycle after start (WAIT_RDY cycle).
- tx_ready is low when start arrives: the block holds in WAIT_RDY indefinitely. There is no timeout there.
- start while busy is ignored. It is not queued.
- start in the same cycle as a done pulse is ignored. The block is still leaving the frame; start is accepted only from IDLE on a later cycle.
- txbuf changes after the start is accepted have no effect on the frame in flight.
- NBYTES=1: exactly one tx_start per frame.
- idx never exceeds NBYTES-1 (the checksum slot is the exception, see Optional Feature).
- Exactly NBYTES tx_start pulses per successful frame.

Optional Feature:
- Macro: UART_BUF_TX_CHECKSUM_EN.
- Defined:
  - After the last data byte completes, one extra byte is sent through the same handshake.
  - The extra byte is the XOR of all NBYTES data bytes.
  - done pulses only after the checksum byte completes.
  - A successful frame has NBYTES+1 tx_start pulses.
  - A timeout on the checksum byte gives err, not done.
- Undefined: no checksum byte, and the checksum logic is absent.

Test Plan:
- Reset, then start with txbuf=32'hA1B2C3D4. The UART model drops ready 1 cycle after tx_start and raises it 10 cycles later -> txbus sequence D4, C3, B2, A1; 4 tx_start pulses; one done pulse; busy low afterwards.
- Checksum variant with UART_BUF_TX_CHECKSUM_EN, txbuf=32'h01020304 -> bytes 04, 03, 02, 01, 04; 5 tx_start pulses; done after the fifth byte.
- Hold tx_ready low for 50 cycles, then pulse start -> no tx_start while ready is low; tx_start 1 cycle after ready rises; no err.
- UART model never drops tx_ready after tx_start, ACK_TIMEOUT=16 -> err pulse 16 cycles after tx_start; state back to IDLE; no done; next start sends normally.
- Change txbuf to 32'hFFFFFFFF and pulse start again mid-frame -> ignored; original bytes sent unchanged; exactly 4 tx_start pulses.
- Assert rst during the second byte, then release, then start with 32'h11223344 -> outputs 0 during reset; no done from the aborted frame; new frame sends 44, 33, 22, 11. Repeat with GAP_CYCLES=3 -> ≥3 idle cycles between the tx_ready rise and the next tx_start.

Source files
------------

// File: rtl/uart_buf_tx.sv
// rtl/uart_buf_tx.sv - word-to-byte serializer feeding the UART transmitter, LSB byte first (optional checksum byte: UART_BUF_TX_CHECKSUM_EN)
module uart_buf_tx #(
    parameter int NBYTES      = 4,
    parameter int GAP_CYCLES  = 0,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] txbuf,
    input  logic        tx_ready,
    output logic        tx_start,
    output logic [7:0]  txbus,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_WAIT_CPL = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    // The checksum byte occupies the slot right after the last data byte.
`ifdef UART_BUF_TX_CHECKSUM_EN
    localparam logic [2:0] NB_W     = 3'(NBYTES);
    localparam logic [2:0] LAST_IDX = 3'(NBYTES);
`else
    localparam logic [2:0] LAST_IDX = 3'(NBYTES - 1);
`endif
    localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [31:0] shadow_q, shadow_d;
    logic [7:0]  cur_byte;

`ifdef UART_BUF_TX_CHECKSUM_EN
    logic [7:0]  csum;

    // XOR of the data bytes actually in use.
    always_comb begin
        csum = 8'h00;
        for (int k = 0; k < 4; k++) begin
            if (k < NBYTES) begin
                csum = csum ^ shadow_q[8*k +: 8];
            end
        end
    end
`endif

    // Select the byte for the current slot of the latched word.
    always_comb begin
        cur_byte = 8'h00;
        case (idx_q)
            3'd0:    cur_byte = shadow_q[7:0];
            3'd1:    cur_byte = shadow_q[15:8];
            3'd2:    cur_byte = shadow_q[23:16];
            3'd3:    cur_byte = shadow_q[31:24];
            default: cur_byte = 8'h00;
        endcase
`ifdef UART_BUF_TX_CHECKSUM_EN
        if (idx_q >= NB_W) begin
            cur_byte = csum;
        end
`endif
    end

    // Next-state and handshake outputs; tx_start/done/err are single-cycle by construction.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        tmo_d    = tmo_q;
        shadow_d = shadow_q;
        tx_start = 1'b0;
        done     = 1'b0;
        err      = 1'b0;
        busy     = (state_q != S_IDLE);
        txbus    = (state_q != S_IDLE) ? cur_byte : 8'h00;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shadow_d = txbuf;
                    idx_d    = 3'd0;
                    gap_d    = 8'd0;
                    tmo_d    = 8'd0;
                    state_d  = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                // No timeout here: a transmitter that is still busy is simply waited on.
                if (tx_ready) begin
                    tx_start = 1'b1;
                    tmo_d    = 8'd0;
                    state_d  = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (!tx_ready) begin
                    state_d = S_WAIT_CPL;
                end else if (tmo_q == ACK_LAST) begin
                    err     = 1'b1;
                    idx_d   = 3'd0;
                    tmo_d   = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            S_WAIT_CPL: begin
                if (tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        done    = 1'b1;
                        idx_d   = 3'd0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        if (GAP_CYCLES > 0) begin
                            gap_d   = 8'd0;
                            state_d = S_GAP;
                        end else begin
                            state_d = S_WAIT_RDY;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = 8'd0;
                    state_d = S_WAIT_RDY;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and latched word; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            gap_q    <= 8'd0;
            tmo_q    <= 8'd0;
            shadow_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            tmo_q    <= tmo_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: tb/tb_uart_buf_tx.sv
// tb/tb_uart_buf_tx.sv - randomized self-checking bench for uart_buf_tx against a word/byte reference model
module tb_uart_buf_tx;

    localparam int ND   = 3;
    localparam int MAXB = 512;
    localparam int HOLD = 10;
    localparam int TMO  = 16;
    localparam int NB0 = 4, GAP0 = 0;
    localparam int NB1 = 4, GAP1 = 3;
    localparam int NB2 = 1, GAP2 = 0;
`ifdef UART_BUF_TX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] txbuf = 32'd0;
    logic        tx_ready [ND];
    logic        tx_start [ND];
    logic [7:0]  txbus    [ND];
    logic        busy     [ND];
    logic        done     [ND];
    logic        err      [ND];

    logic force_low = 1'b0;
    logic noack     = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sc_g = 0;

    logic [7:0] gotb   [ND][MAXB];
    int         st_cyc [ND][MAXB];
    int         got_n  [ND];
    int         done_n [ND];
    int         err_n  [ND];
    int         err_cyc[ND];
    int         seen   [ND];
    int         mcnt   [ND];
    int         b_got  [ND];
    int         b_done [ND];
    int         b_err  [ND];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_buf_tx #(.NBYTES(NB0), .GAP_CYCLES(GAP0), .ACK_TIMEOUT(TMO)) dut0 (
        .clk(clk), .rst(rst), .start(start), .txbuf(txbuf), .tx_ready(tx_ready[0]),
        .tx_start(tx_start[0]), .txbus(txbus[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));
    uart_buf_tx #(.NBYTES(NB1), .GAP_CYCLES(GAP1), .ACK_TIMEOUT(TMO)) dut1 (
        .clk(clk), .rst(rst), .start(start), .txbuf(txbuf), .tx_ready(tx_ready[1]),
        .tx_start(tx_start[1]), .txbus(txbus[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));
    uart_buf_tx #(.NBYTES(NB2), .GAP_CYCLES(GAP2), .ACK_TIMEOUT(TMO)) dut2 (
        .clk(clk), .rst(rst), .start(start), .txbuf(txbuf), .tx_ready(tx_ready[2]),
        .tx_start(tx_start[2]), .txbus(txbus[2]), .busy(busy[2]), .done(done[2]), .err(err[2]));

    function automatic int nbv(input int d);
        case (d)
            0:       return NB0;
            1:       return NB1;
            default: return NB2;
        endcase
    endfunction

    function automatic int gapv(input int d);
        case (d)
            0:       return GAP0;
            1:       return GAP1;
            default: return GAP2;
        endcase
    endfunction

    function automatic int ref_len(input int d);
        return nbv(d) + CS;
    endfunction

    // Byte k of a frame: data bytes LSB first, then the XOR of all data bytes.
    function automatic logic [7:0] ref_byte(input int d, input logic [31:0] w, input int k);
        logic [7:0] x;
        x = 8'h00;
        if (k < nbv(d)) return 8'((w >> (8 * k)) & 32'hFF);
        for (int j = 0; j < nbv(d); j++) x = x ^ 8'((w >> (8 * j)) & 32'hFF);
        return x;
    endfunction

    // Record every handshake event seen on each DUT.
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (!rst) begin
                if (tx_start[d] === 1'b1) begin
                    if (got_n[d] < MAXB) begin
                        gotb[d][got_n[d]]   <= txbus[d];
                        st_cyc[d][got_n[d]] <= cyc;
                    end
                    got_n[d] <= got_n[d] + 1;
                end
                if (done[d] === 1'b1) done_n[d] <= done_n[d] + 1;
                if (err[d] === 1'b1) begin
                    err_n[d]   <= err_n[d] + 1;
                    err_cyc[d] <= cyc;
                end
            end
        end
    end

    // UART transmitter model: ready drops the cycle after tx_start and returns HOLD cycles later.
    always begin
        @(posedge clk);
        #2;
        for (int d = 0; d < ND; d++) begin
            if (rst) begin
                tx_ready[d] = 1'b1; mcnt[d] = 0; seen[d] = got_n[d];
            end else if (force_low) begin
                tx_ready[d] = 1'b0; mcnt[d] = 0; seen[d] = got_n[d];
            end else if (seen[d] != got_n[d]) begin
                seen[d] = got_n[d];
                if (!noack) begin
                    tx_ready[d] = 1'b0; mcnt[d] = HOLD;
                end
            end else if (mcnt[d] > 0) begin
                mcnt[d] = mcnt[d] - 1;
                if (mcnt[d] == 0) tx_ready[d] = 1'b1;
            end else begin
                tx_ready[d] = 1'b1;
            end
        end
    end

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        for (int d = 0; d < ND; d++) begin
            b_got[d] = got_n[d]; b_done[d] = done_n[d]; b_err[d] = err_n[d];
        end
    endtask

    task automatic pulse_start(input logic [31:0] w);
        drv();
        txbuf = w; start = 1'b1; sc_g = cyc;
        drv();
        start = 1'b0;
    endtask

    task automatic wait_all(input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            smp();
            ok = 1'b1;
            for (int d = 0; d < ND; d++)
                if (done_n[d] + err_n[d] <= b_done[d] + b_err[d]) ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        smp();
        for (int d = 0; d < ND; d++) begin
            checks++; if (tx_start[d] !== 1'b0) begin errors++; $display("FAIL reset_tx_start dut%0d: got %b expected 0", d, tx_start[d]); end
            checks++; if (txbus[d] !== 8'h00) begin errors++; $display("FAIL reset_txbus dut%0d: got %h expected 00", d, txbus[d]); end
            checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: got %b expected 0", d, busy[d]); end
            checks++; if (done[d] !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d: got %b expected 0", d, done[d]); end
            checks++; if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_err dut%0d: got %b expected 0", d, err[d]); end
        end
        drv();
        rst = 1'b0;
        repeat (2) drv();
    endtask

    task automatic test_basic();
        logic ok;
        logic [31:0] w;
        w = 32'hA1B2C3D4;
        snap();
        pulse_start(w);
        smp();
        for (int d = 0; d < ND; d++) begin
            checks++; if (busy[d] !== 1'b1) begin errors++; $display("FAIL basic_busy_on dut%0d: got %b expected 1", d, busy[d]); end
        end
        wait_all(500, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_wait: got no completion expected done"); end
        smp();
        for (int d = 0; d < ND; d++) begin
            checks++; if (got_n[d] - b_got[d] !== ref_len(d)) begin errors++; $display("FAIL basic_count dut%0d: got %0d expected %0d", d, got_n[d] - b_got[d], ref_len(d)); end
            checks++; if (st_cyc[d][b_got[d]] !== sc_g + 1) begin errors++; $display("FAIL basic_latency dut%0d: got cycle %0d expected %0d", d, st_cyc[d][b_got[d]], sc_g + 1); end
            for (int k = 0; k < ref_len(d) && k < got_n[d] - b_got[d]; k++) begin
                checks++; if (gotb[d][b_got[d] + k] !== ref_byte(d, w, k)) begin errors++; $display("FAIL basic_byte%0d dut%0d: got %h expected %h", k, d, gotb[d][b_got[d] + k], ref_byte(d, w, k)); end
                if (k > 0) begin
                    checks++; if (st_cyc[d][b_got[d] + k] - st_cyc[d][b_got[d] + k - 1] !== HOLD + 2 + gapv(d)) begin errors++; $display("FAIL basic_spacing%0d dut%0d: got %0d expected %0d", k, d, st_cyc[d][b_got[d] + k] - st_cyc[d][b_got[d] + k - 1], HOLD + 2 + gapv(d)); end
                end
            end
            checks++; if (done_n[d] - b_done[d] !== 1) begin errors++; $display("FAIL basic_done dut%0d: got %0d expected 1", d, done_n[d] - b_done[d]); end
            checks++; if (err_n[d] - b_err[d] !== 0) begin errors++; $display("FAIL basic_err dut%0d: got %0d expected 0", d, err_n[d] - b_err[d]); end
            checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL basic_busy_off dut%0d: got %b expected 0", d, busy[d]); end
        end
    endtask

    task automatic test_ready_low();
        logic ok;
        logic [31:0] w;
        int r;
        w = $urandom;
        force_low = 1'b1;
        repeat (3) drv();
        snap();
        pulse_start(w);
        repeat (50) smp();
        for (int d = 0; d < ND; d++) begin
            checks++; if (got_n[d] - b_got[d] !== 0) begin errors++; $display("FAIL rdylow_no_start dut%0d: got %0d expected 0", d, got_n[d] - b_got[d]); end
            checks++; if (err_n[d] - b_err[d] !== 0) begin errors++; $display("FAIL rdylow_no_err dut%0d: got %0d expected 0", d, err_n[d] - b_err[d]); end
            checks++; if (busy[d] !== 1'b1) begin errors++; $display("FAIL rdylow_busy dut%0d: got %b expected 1", d, busy[d]); end
        end
        drv();
        force_low = 1'b0;
        r = cyc;
        wait_all(500, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rdylow_wait: got no completion expected done"); end
        smp();
        for (int d = 0; d < ND; d++) begin
            checks++; if (st_cyc[d][b_got[d]] < r || st_cyc[d][b_got[d]] > r + 1) begin errors++; $display("FAIL rdylow_latency dut%0d: got cycle %0d expected %0d..%0d", d, st_cyc[d][b_got[d]], r, r + 1); end
            checks++; if (got_n[d] - b_got[d] !== ref_len(d)) begin errors++; $display("FAIL rdylow_count dut%0d: got %0d expected %0d", d, got_n[d] - b_got[d], ref_len(d)); end
            for (int k = 0; k < ref_len(d) && k < got_n[d] - b_got[d]; k++) begin
                checks++; if (gotb[d][b_got[d] + k] !== ref_byte(d, w, k)) begin errors++; $display("FAIL rdylow_byte%0d dut%0d: got %h expected %h", k, d, gotb[d][b_got[d] + k], ref_byte(d, w, k)); end
            end
            checks++; if (err_n[d] - b_err[d] !== 0) begin errors++; $display("FAIL rdylow_err dut%0d: got %0d expected 0", d, err_n[d] - b_err[d]); end
            checks++; if (done_n[d] - b_done[d] !== 1) begin errors++; $display("FAIL rdylow_done dut%0d: got %0d expected 1", d, done_n[d] - b_done[d]); end
        end
    endtask

    task automatic test_timeout();
        logic ok;
        logic [31:0] w;
        noack = 1'b1;
        snap();
        pulse_start($urandom);
        wait_all(200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_wait: got no event expected err"); end
        smp();
        for (int d = 0; d < ND; d++) begin
            checks++; if (err_n[d] - b_err[d] !== 1) begin errors++; $display("FAIL tmo_err dut%0d: got %0d expected 1", d, err_n[d] - b_err[d]); end
            checks++; if (done_n[d] - b_done[d] !== 0) begin errors++; $display("FAIL tmo_done dut%0d: got %0d expected 0", d, done_n[d] - b_done[d]); end
            checks++; if (got_n[d] - b_got[d] !== 1) begin errors++; $display("FAIL tmo_starts dut%0d: got %0d expected 1", d, got_n[d] - b_got[d]); end
            checks++; if (err_cyc[d] - st_cyc[d][b_got[d]] !== TMO) begin errors++; $display("FAIL tmo_delay dut%0d: got %0d expected %0d", d, err_cyc[d] - st_cyc[d][b_got[d]], TMO); end
            checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL tmo_busy dut%0d: got %b expected 0", d, busy[d]); end
        end
        noack = 1'b0;
        w = $urandom;
        snap();
        pulse_start(w);
        wait_all(500, ok);
        smp();
        for (int d = 0; d < ND; d++) begin
            checks++; if (got_n[d] - b_got[d] !== ref_len(d)) begin errors++; $display("FAIL tmo_next_count dut%0d: got %0d expected %0d", d, got_n[d] - b_got[d], ref_len(d)); end
            for (int k = 0; k < ref_len(d) && k < got_n[d] - b_got[d]; k++) begin
                checks++; if (gotb[d][b_got[d] + k] !== ref_byte(d, w, k)) begin errors++; $display("FAIL tmo_next_byte%0d dut%0d: got %h expected %h", k, d, gotb[d][b_got[d] + k], ref_byte(d, w, k)); end
            end
            checks++; if (done_n[d] - b_done[d] !== 1) begin errors++; $display("FAIL tmo_next_done dut%0d: got %0d expected 1", d, done_n[d] - b_done[d]); end
        end
    endtask

    task automatic test_ignore_start();
        logic ok;
        logic [31:0] w;
        w = $urandom;
        snap();
        pulse_start(w);
        repeat (3) drv();
        txbuf = 32'hFFFFFFFF;
        start = 1'b1;
        drv();
        start = 1'b0;
        wait_all(500, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ign_wait: got no completion expected done"); end
        repeat (20) smp();
        for (int d = 0; d < ND; d++) begin
            checks++; if (got_n[d] - b_got[d] !== ref_len(d)) begin errors++; $display("FAIL ign_count dut%0d: got %0d expected %0d", d, got_n[d] - b_got[d], ref_len(d)); end
            for (int k = 0; k < ref_len(d) && k < got_n[d] - b_got[d]; k++) begin
                checks++; if (gotb[d][b_got[d] + k] !== ref_byte(d, w, k)) begin errors++; $display("FAIL ign_byte%0d dut%0d: got %h expected %h", k, d, gotb[d][b_got[d] + k], ref_byte(d, w, k)); end
            end
            checks++; if (done_n[d] - b_done[d] !== 1) begin errors++; $display("FAIL ign_done dut%0d: got %0d expected 1", d, done_n[d] - b_done[d]); end
            checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL ign_busy dut%0d: got %b expected 0", d, busy[d]); end
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        logic [31:0] w;
        int pre_done [ND];
        int pre_err  [ND];
        snap();
        pulse_start($urandom);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            smp();
            ok = (got_n[1] - b_got[1] >= 2);
        end
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_wait: got %0d starts expected 2", got_n[1] - b_got[1]); end
        for (int d = 0; d < ND; d++) begin pre_done[d] = done_n[d]; pre_err[d] = err_n[d]; end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            checks++; if (tx_start[d] !== 1'b0) begin errors++; $display("FAIL rstmid_tx_start dut%0d: got %b expected 0", d, tx_start[d]); end
            checks++; if (txbus[d] !== 8'h00) begin errors++; $display("FAIL rstmid_txbus dut%0d: got %h expected 00", d, txbus[d]); end
            checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL rstmid_busy dut%0d: got %b expected 0", d, busy[d]); end
            checks++; if (done[d] !== 1'b0 || err[d] !== 1'b0) begin errors++; $display("FAIL rstmid_flags dut%0d: got done %b err %b expected 0 0", d, done[d], err[d]); end
        end
        repeat (2) drv();
        rst = 1'b0;
        repeat (3) drv();
        for (int d = 0; d < ND; d++) begin
            checks++; if (done_n[d] !== pre_done[d] || err_n[d] !== pre_err[d]) begin errors++; $display("FAIL rstmid_aborted dut%0d: got done+%0d err+%0d expected none", d, done_n[d] - pre_done[d], err_n[d] - pre_err[d]); end
        end
        w = 32'h11223344;
        snap();
        pulse_start(w);
        wait_all(500, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rstmid_next_wait: got no completion expected done"); end
        smp();
        for (int d = 0; d < ND; d++) begin
            checks++; if (got_n[d] - b_got[d] !== ref_len(d)) begin errors++; $display("FAIL rstmid_count dut%0d: got %0d expected %0d", d, got_n[d] - b_got[d], ref_len(d)); end
            for (int k = 0; k < ref_len(d) && k < got_n[d] - b_got[d]; k++) begin
                checks++; if (gotb[d][b_got[d] + k] !== ref_byte(d, w, k)) begin errors++; $display("FAIL rstmid_byte%0d dut%0d: got %h expected %h", k, d, gotb[d][b_got[d] + k], ref_byte(d, w, k)); end
                if (k > 0) begin
                    checks++; if (st_cyc[d][b_got[d] + k] - (st_cyc[d][b_got[d] + k - 1] + HOLD + 1) - 1 < gapv(d)) begin errors++; $display("FAIL rstmid_gap%0d dut%0d: got %0d idle expected >= %0d", k, d, st_cyc[d][b_got[d] + k] - (st_cyc[d][b_got[d] + k - 1] + HOLD + 1) - 1, gapv(d)); end
                end
            end
            checks++; if (done_n[d] - b_done[d] !== 1) begin errors++; $display("FAIL rstmid_done dut%0d: got %0d expected 1", d, done_n[d] - b_done[d]); end
        end
    endtask

    task automatic test_back_to_back();
        logic ok;
        logic [31:0] w;
        for (int it = 0; it < 5; it++) begin
            w = $urandom;
            snap();
            pulse_start(w);
            wait_all(500, ok);
            checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_wait it%0d: got no completion expected done", it); end
            smp();
            for (int d = 0; d < ND; d++) begin
                checks++; if (st_cyc[d][b_got[d]] !== sc_g + 1) begin errors++; $display("FAIL b2b_latency it%0d dut%0d: got %0d expected %0d", it, d, st_cyc[d][b_got[d]], sc_g + 1); end
                checks++; if (got_n[d] - b_got[d] !== ref_len(d)) begin errors++; $display("FAIL b2b_count it%0d dut%0d: got %0d expected %0d", it, d, got_n[d] - b_got[d], ref_len(d)); end
                for (int k = 0; k < ref_len(d) && k < got_n[d] - b_got[d]; k++) begin
                    checks++; if (gotb[d][b_got[d] + k] !== ref_byte(d, w, k)) begin errors++; $display("FAIL b2b_byte%0d it%0d dut%0d: got %h expected %h", k, it, d, gotb[d][b_got[d] + k], ref_byte(d, w, k)); end
                end
                checks++; if (done_n[d] - b_done[d] !== 1 || err_n[d] - b_err[d] !== 0) begin errors++; $display("FAIL b2b_status it%0d dut%0d: got done %0d err %0d expected 1 0", it, d, done_n[d] - b_done[d], err_n[d] - b_err[d]); end
                checks++; if (busy[d] !== 1'b0) begin errors++; $display("FAIL b2b_busy it%0d dut%0d: got %b expected 0", it, d, busy[d]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_low();
        test_timeout();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
